// File: rtl/sym_mod_pkg.sv
// Shared definitions for the OFDM symbol mapper: modulation codes,
// 16-bit constellation levels, FSM states and the Gray map helper.
package sym_mod_pkg;

    localparam logic [1:0] MOD_QPSK = 2'b00;
    localparam logic [1:0] MOD_BPSK = 2'b01;
    localparam logic [1:0] MOD_16Q  = 2'b10;
    localparam logic [1:0] MOD_64Q  = 2'b11;

    localparam logic [15:0] Q64_P7 = 16'h7FFF;
    localparam logic [15:0] Q64_P5 = 16'h62C1;
    localparam logic [15:0] Q64_P3 = 16'h3B41;
    localparam logic [15:0] Q64_P1 = 16'h13C0;
    localparam logic [15:0] Q64_M1 = 16'hEC40;
    localparam logic [15:0] Q64_M3 = 16'hC2BF;
    localparam logic [15:0] Q64_M5 = 16'h9D3F;
    localparam logic [15:0] Q64_M7 = 16'h8001;

    localparam logic [15:0] Q16_P3 = 16'h796E;
    localparam logic [15:0] Q16_P1 = 16'h287A;
    localparam logic [15:0] Q16_M1 = 16'hD786;
    localparam logic [15:0] Q16_M3 = 16'h8692;

    localparam logic [15:0] QPSK_P = 16'h5A82;
    localparam logic [15:0] QPSK_M = 16'hA57E;

    localparam logic [15:0] BPSK_P = 16'h7FFF;
    localparam logic [15:0] BPSK_M = 16'h8001;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [15:0] im;
        logic [15:0] re;
    } iq16_t;

    function automatic logic [15:0] q64_lvl(input logic [2:0] f);
        logic [15:0] v;
        case (f)
            3'b011:  v = Q64_P7;
            3'b010:  v = Q64_P5;
            3'b000:  v = Q64_P3;
            3'b001:  v = Q64_P1;
            3'b101:  v = Q64_M1;
            3'b100:  v = Q64_M3;
            3'b110:  v = Q64_M5;
            default: v = Q64_M7;
        endcase
        return v;
    endfunction

    function automatic logic [15:0] q16_lvl(input logic [1:0] f);
        logic [15:0] v;
        case (f)
            2'b01:   v = Q16_P3;
            2'b00:   v = Q16_P1;
            2'b10:   v = Q16_M1;
            default: v = Q16_M3;
        endcase
        return v;
    endfunction

    function automatic iq16_t map16(
        input logic [1:0] m,
        input logic [5:0] d
    );
        iq16_t s;
        case (m)
            MOD_QPSK: begin
                s.im = d[1] ? QPSK_M : QPSK_P;
                s.re = d[0] ? QPSK_M : QPSK_P;
            end
            MOD_BPSK: begin
                s.im = d[0] ? BPSK_M : BPSK_P;
                s.re = '0;
            end
            MOD_16Q: begin
                s.im = q16_lvl(d[3:2]);
                s.re = q16_lvl(d[1:0]);
            end
            default: begin
                s.im = q64_lvl(d[5:3]);
                s.re = q64_lvl(d[2:0]);
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sym_fifo.sv
// Output FIFO with wrap-bit pointers and a registered head word.
// Ports: push/wdata in, pop in, head/full/empty out.
module sym_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_nxt;
    logic [AW:0]      rd_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign wr_nxt  = wr_ptr + {{AW{1'b0}}, push_ok};
    assign rd_nxt  = rd_ptr + {{AW{1'b0}}, pop_ok};

    always_ff @(posedge CLK_I) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Head is preloaded so the next entry shows up on the edge it
    // becomes the oldest; if that entry is being written now, it
    // comes straight from wdata.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            if (wr_nxt != rd_nxt) begin
                if (rd_nxt == wr_ptr) begin
                    head <= wdata;
                end else begin
                    head <= mem[rd_nxt[AW-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/sym_mapper_fifo.sv
// Gray-coded BPSK/QPSK/16QAM/64QAM mapper with buffered IQ output.
// Ports: WB-style stream in (DAT_I/CYC/STB/WE/ACK_O), out (DAT_O...).
import sym_mod_pkg::*;

module sym_mapper_fifo #(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 12
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [5:0]        DAT_I,
    input  logic              CYC_I,
    input  logic              STB_I,
    input  logic              WE_I,
    output logic              ACK_O,
    output logic [2*DW-1:0]   DAT_O,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    input  logic              ACK_I,
    input  logic [1:0]        MOD,
    output logic [CNT_W-1:0]  SYM_CNT
);

    localparam int SH = 16 - DW;

    state_t             state;
    logic [1:0]         mod_r;
    logic [1:0]         mod_eff;
    iq16_t              iq;
    logic signed [15:0] im_s;
    logic signed [15:0] re_s;
    logic [2*DW-1:0]    wdata;
    logic               full;
    logic               empty;
    logic               accept;
    logic               pop;

    // On the frame-start edge mod_r is not loaded yet, so the
    // live MOD input selects the map for that first word.
    assign mod_eff = (state == IDLE) ? MOD : mod_r;
    assign iq      = map16(mod_eff, DAT_I);
    assign im_s    = $signed(iq.im) >>> SH;
    assign re_s    = $signed(iq.re) >>> SH;
    assign wdata   = {im_s[DW-1:0], re_s[DW-1:0]};

    assign accept = CYC_I & STB_I & WE_I & ~full &
                    (state != DRAIN);
    assign ACK_O  = accept;
    assign STB_O  = ~empty;
    assign WE_O   = ~empty;
    assign pop    = ~empty & ACK_I;
    assign CYC_O  = (state != IDLE);

    sym_fifo #(
        .WIDTH (2*DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .push  (accept),
        .wdata (wdata),
        .pop   (pop),
        .head  (DAT_O),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state   <= IDLE;
            mod_r   <= MOD_QPSK;
            SYM_CNT <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (CYC_I) begin
                        state   <= ACTIVE;
                        mod_r   <= MOD;
                        SYM_CNT <= accept ? CNT_W'(1) : '0;
                    end
                end
                ACTIVE: begin
                    if (!CYC_I) begin
                        state <= DRAIN;
                    end
                    if (accept && (SYM_CNT != '1)) begin
                        SYM_CNT <= SYM_CNT + 1'b1;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
